pingpong_delay_line: RTL
========================

Name: pingpong_delay_line

Overview:
Input buffering stage that sits directly upstream of the transform engines (HWT/DCT/DFT) and their controller. It collects a serial stream of 9-bit samples into 8-sample blocks using two alternating banks (ping/pong). It presents one complete block as a 72-bit parallel word while the next block fills. A valid/taken handshake with the downstream controller decides when a bank is released and when the banks swap.

Parameters:
DATA_W, 9, width of one sample
DEPTH, 8, samples per block
CNT_W, 4, width of the fill counter (must hold 0..DEPTH)

Ports:
clock  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  global enable; 0 freezes all state
data_load  input  1  load window; samples are accepted only while 1
din  input  DATA_W  serial sample in
din_valid  input  1  din carries a sample this cycle
din_ready  output  1  block can accept a sample this cycle
pong  output  DATA_W*DEPTH  read-bank block; sample k of the block at bits [k*DATA_W +: DATA_W]
valid  output  1  pong holds a complete, unconsumed block
taken  input  1  downstream has consumed pong (acts only when valid=1)
count  output  CNT_W  samples currently held in the write bank, 0..DEPTH
bank_sel  output  1  bank currently driving pong (0 = A, 1 = B)
overflow  output  1  sticky: a sample was offered while the block was stalled

Behaviour:
- Reset (rst=1 at a clock edge): state=EMPTY, count=0, valid=0, bank_sel=0, overflow=0, pong=0, both banks cleared. The write bank is B. Reset in the middle of a fill discards the partial block. Reset takes priority over en.
- Accept rule: a sample is accepted when en & data_load & din_valid & din_ready.
- din_ready = en & data_load & (count < DEPTH). It is combinational from state and inputs.
- An accepted sample is written to write-bank slot [count], then count increments. The first sample of a block lands at pong bits [8:0].
- en=0: no accept, no swap. taken is ignored. All registers hold their values.
- data_load=0 with en=1: no accept. The handshake and swap logic keep running.
- State machine:
  - EMPTY: no valid block. Writes fill the write bank.
  - STREAM: valid=1. The read bank drives pong, and the write bank keeps filling.
  - STALL: read bank unconsumed and write bank full (count=DEPTH). din_ready=0.
- Swap: on the edge where the write bank becomes full, or is already full, and the read bank is free (valid=0, or taken=1 in the same cycle):
  - bank_sel toggles, count becomes 0, and valid=1 from the next cycle.
  - pong shows the new block in the cycle after that edge.
- Latency: the 8th sample is accepted at edge N. If the read bank is free, valid=1 and pong are updated at edge N, i.e. visible in cycle N+1. Latency is 1 cycle from the last sample to the block output.
- Transitions:
  - EMPTY→STREAM on a swap.
  - STREAM→STREAM on a swap with taken=1.
  - STREAM→EMPTY when taken=1 and the write bank is not full (valid clears next cycle).
  - STREAM→STALL when the write bank fills while valid=1 and taken=0.
  - STALL→STREAM when taken=1, with the swap on the same edge, so valid stays 1 with no gap.
- Simultaneous events:
  - taken on the same edge as the 8th write: swap happens, valid stays 1, and pong shows the new block.
  - taken when valid=0: ignored.
- Overflow: set when en & data_load & din_valid & count==DEPTH. It stays set until rst; samples offered in that state are dropped.
- count never exceeds DEPTH, and there is no wrap-around: it only returns to 0 through a swap or reset.
- The read bank contents never change while valid=1.

Test Plan:
- Reset, then drive 8 samples 1..8 back-to-back with data_load=1 → valid rises in the cycle after sample 8; pong = {9'd8,...,9'd1}; bank_sel=1; count=0.
- Continuous stream of 24 samples, with taken pulsed one cycle after each valid rise → three blocks appear in order, bank_sel alternates 1,0,1, and din_ready stays 1 throughout.
- Fill block 1, hold taken=0, drive 8 more samples then a 17th → count=8, state STALL, din_ready=0, overflow=1, and the 17th sample is lost. Assert taken → valid stays 1 with block 2 and count=0.
- taken asserted on the same edge as sample 8 of block 2 → no valid gap, and pong switches to block 2 the next cycle.
- Drop en to 0 for 5 cycles in the middle of a fill (after sample 3) with din_valid=1 and taken=1 → count stays 3 and valid/pong are unchanged. Resume → the block completes with the correct contents.
- Assert rst after 5 samples → count=0, valid=0, overflow=0. The next 8 samples form a clean block with no stale data.

Source files
------------

// File: rtl/pingpong_delay_line.sv
// Ping/pong input buffer: collects serial samples into DEPTH-sample blocks in
// two alternating banks and presents one complete block while the other fills.
module pingpong_delay_line #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      data_load,
  input  logic [DATA_W-1:0]         din,
  input  logic                      din_valid,
  output logic                      din_ready,
  output logic [DATA_W*DEPTH-1:0]   pong,
  output logic                      valid,
  input  logic                      taken,
  output logic [CNT_W-1:0]          count,
  output logic                      bank_sel,
  output logic                      overflow
);

  // state  | meaning
  // EMPTY  | no block presented; write bank filling
  // STREAM | read bank presented (valid=1); write bank filling
  // STALL  | read bank unconsumed and write bank full; input blocked
  typedef enum logic [1:0] {EMPTY, STREAM, STALL} state_t;

  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(DEPTH - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          count_q, count_d;
  logic                      bank_sel_q, bank_sel_d;
  logic                      ovf_q, ovf_d;
  logic [DATA_W*DEPTH-1:0]   bank_a_q, bank_a_d;
  logic [DATA_W*DEPTH-1:0]   bank_b_q, bank_b_d;
  logic                      accept;
  logic                      wr_full;
  logic                      swap;

  assign din_ready = en & data_load & (count_q < FULL_C);
  assign accept    = din_ready & din_valid;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    bank_sel_d = bank_sel_q;
    ovf_d      = ovf_q;
    bank_a_d   = bank_a_q;
    bank_b_d   = bank_b_q;
    wr_full    = 1'b0;
    swap       = 1'b0;
    if (en) begin
      // bank_sel names the read bank, so samples go to the other one
      if (accept) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (count_q == CNT_W'(k)) begin
            if (bank_sel_q) bank_a_d[k*DATA_W +: DATA_W] = din;
            else            bank_b_d[k*DATA_W +: DATA_W] = din;
          end
        end
        count_d = count_q + CNT_W'(1);
      end
      if (data_load && din_valid && (count_q == FULL_C)) ovf_d = 1'b1;
      wr_full = (count_q == FULL_C) || (accept && (count_q == LAST_C));
      unique case (state_q)
        EMPTY: begin
          if (wr_full) swap = 1'b1;
        end
        STREAM: begin
          if (wr_full && taken) swap = 1'b1;
          else if (taken)       state_d = EMPTY;
          else if (wr_full)     state_d = STALL;
        end
        STALL: begin
          if (taken) swap = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
      if (swap) begin
        state_d    = STREAM;
        bank_sel_d = ~bank_sel_q;
        count_d    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q    <= EMPTY;
      count_q    <= '0;
      bank_sel_q <= 1'b0;
      ovf_q      <= 1'b0;
      bank_a_q   <= '0;
      bank_b_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      bank_sel_q <= bank_sel_d;
      ovf_q      <= ovf_d;
      bank_a_q   <= bank_a_d;
      bank_b_q   <= bank_b_d;
    end
  end

  assign valid    = (state_q != EMPTY);
  assign pong     = bank_sel_q ? bank_b_q : bank_a_q;
  assign count    = count_q;
  assign bank_sel = bank_sel_q;
  assign overflow = ovf_q;

endmodule
